qpsk_shaper_gen2: RTL

QPSK_SHAPER_GEN2 -- requirements
Module: qpsk_shaper_gen2

---
 rtl/qpsk_shaper_gen2.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/qpsk_shaper_gen2.sv
// QPSK/BPSK pulse shaper: polyphase FIR over ternary symbol taps, rounding and
// saturation to DAC width, plus an fs/4 digital upconverted IF output.
module qpsk_shaper_gen2 #(
    parameter int unsigned SPS       = 8,
    parameter int unsigned SPAN      = 16,
    parameter int unsigned COEF_W    = 14,
    parameter int unsigned DAC_W     = 14,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  sym_valid,
    output logic                                  sym_ready,
    input  logic [1:0]                            symbol,
    input  logic                                  mode,
    input  logic                                  coef_we,
    input  logic [$clog2((SPAN+1)*SPS)-1:0]       coef_addr,
    input  logic signed [COEF_W-1:0]              coef_data,
    output logic signed [DAC_W-1:0]               i_out,
    output logic signed [DAC_W-1:0]               q_out,
    output logic signed [DAC_W-1:0]               if_out,
    output logic                                  out_valid,
    output logic                                  underrun
);

    localparam int unsigned TAPS  = SPAN + 1;
    localparam int unsigned DEPTH = TAPS * SPS;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = $clog2(SPS);
    localparam int unsigned PRW   = COEF_W + 1;
    localparam int unsigned ACC_W = COEF_W + $clog2(TAPS) + 1;
    localparam int unsigned RW    = ACC_W + 1;

    // Ternary amplitude encoding: bit0 = non-zero, bit1 = negative
    localparam logic [1:0] AMP_ZERO = 2'b00;
    localparam logic [1:0] AMP_POS  = 2'b01;
    localparam logic [1:0] AMP_NEG  = 2'b11;

    localparam logic signed [RW-1:0]    HALF    = (RW'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [RW-1:0]    SAT_HI  = RW'(2 ** (DAC_W - 1) - 1);
    localparam logic signed [RW-1:0]    SAT_LO  = RW'(-(2 ** (DAC_W - 1)));
    localparam logic signed [DAC_W-1:0] DAC_MAX = DAC_W'(2 ** (DAC_W - 1) - 1);
    localparam logic signed [DAC_W-1:0] DAC_MIN = DAC_W'(-(2 ** (DAC_W - 1)));

    logic [PW-1:0]             phase;
    logic [1:0]                mix_cnt;
    logic [1:0]                vld_cnt;
    logic                      phase_last;
    logic [1:0]                new_i;
    logic [1:0]                new_q;
    logic [1:0]                tap_i   [TAPS];
    logic [1:0]                tap_q   [TAPS];
    logic signed [COEF_W-1:0]  coef_mem [DEPTH];
    logic signed [COEF_W-1:0]  coef_tap [TAPS];
    logic signed [PRW-1:0]     prod_i  [TAPS];
    logic signed [PRW-1:0]     prod_q  [TAPS];
    logic signed [ACC_W-1:0]   sum_i;
    logic signed [ACC_W-1:0]   sum_q;
    logic signed [ACC_W-1:0]   acc_i;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [DAC_W-1:0]   i_pre;
    logic signed [DAC_W-1:0]   q_pre;
    logic signed [DAC_W-1:0]   if_pre;

    // Multiply a coefficient by a ternary amplitude
    function automatic logic signed [PRW-1:0] apply_amp(input logic [1:0] amp,
                                                        input logic signed [COEF_W-1:0] c);
        case (amp)
            AMP_POS: return PRW'(c);
            AMP_NEG: return -PRW'(c);
            default: return '0;
        endcase
    endfunction

    // Arithmetic shift with round-half-up, then saturate to DAC range
    function automatic logic signed [DAC_W-1:0] scale(input logic signed [ACC_W-1:0] a);
        logic signed [RW-1:0] rnd;
        rnd = (RW'(a) + HALF) >>> OUT_SHIFT;
        if (rnd > SAT_HI)      return DAC_MAX;
        else if (rnd < SAT_LO) return DAC_MIN;
        else                   return DAC_W'(rnd);
    endfunction

    // Negation that maps the most negative code to full-scale positive
    function automatic logic signed [DAC_W-1:0] neg_sat(input logic signed [DAC_W-1:0] x);
        if (x == DAC_MIN) return DAC_MAX;
        else              return -x;
    endfunction

    assign phase_last = (phase == PW'(SPS - 1));

    // Entry loaded into tap0 at a symbol slot; BPSK forces Q to zero
    always_comb begin
        new_i = AMP_ZERO;
        new_q = AMP_ZERO;
        if (sym_valid) begin
            new_i = symbol[0] ? AMP_NEG : AMP_POS;
            if (!mode) new_q = symbol[1] ? AMP_NEG : AMP_POS;
        end
    end

    // Phase/mix counters, slot handshake, underrun flag and fill tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase     <= '0;
            mix_cnt   <= '0;
            vld_cnt   <= '0;
            sym_ready <= 1'b0;
            underrun  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            phase     <= phase + PW'(1);
            mix_cnt   <= mix_cnt + 2'd1;
            sym_ready <= (phase == PW'(SPS - 2));
            underrun  <= phase_last & ~sym_valid;
            if (!out_valid) vld_cnt <= vld_cnt + 2'd1;
            out_valid <= out_valid | (vld_cnt == 2'd2);
        end
    end

    // Symbol tap lines shift once per symbol slot
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                tap_i[k] <= AMP_ZERO;
                tap_q[k] <= AMP_ZERO;
            end
        end else if (phase_last) begin
            tap_i[0] <= new_i;
            tap_q[0] <= new_q;
            for (int unsigned k = 1; k < TAPS; k++) begin
                tap_i[k] <= tap_i[k-1];
                tap_q[k] <= tap_q[k-1];
            end
        end
    end

    // Coefficient RAM: not reset, write visible to reads from the next cycle
    always_ff @(posedge clock) begin
        if (coef_we) coef_mem[coef_addr] <= coef_data;
    end

    // Per-tap coefficient fetch for the current phase
    always_comb begin
        for (int unsigned k = 0; k < TAPS; k++) begin
            coef_tap[k] = coef_mem[AW'(k * SPS) + AW'(phase)];
        end
    end

    // Stage 1: registered per-tap products
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                prod_i[k] <= '0;
                prod_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                prod_i[k] <= apply_amp(tap_i[k], coef_tap[k]);
                prod_q[k] <= apply_amp(tap_q[k], coef_tap[k]);
            end
        end
    end

    // Adder tree over all tap products
    always_comb begin
        sum_i = '0;
        sum_q = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            sum_i = sum_i + ACC_W'(prod_i[k]);
            sum_q = sum_q + ACC_W'(prod_q[k]);
        end
    end

    // Stage 2: registered sums
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_i <= '0;
            acc_q <= '0;
        end else begin
            acc_i <= sum_i;
            acc_q <= sum_q;
        end
    end

    // Scaled baseband and fs/4 mix selection ahead of the output register
    always_comb begin
        i_pre  = scale(acc_i);
        q_pre  = scale(acc_q);
        if_pre = i_pre;
        case (mix_cnt)
            2'd0:    if_pre = i_pre;
            2'd1:    if_pre = neg_sat(q_pre);
            2'd2:    if_pre = neg_sat(i_pre);
            default: if_pre = q_pre;
        endcase
    end

    // Stage 3: registered DAC outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_out  <= '0;
            q_out  <= '0;
            if_out <= '0;
        end else begin
            i_out  <= i_pre;
            q_out  <= q_pre;
            if_out <= if_pre;
        end
    end

endmodule
